// File: rtl/wide_uart_deframer.sv
// Frame parser behind the 64-bit UART bridge: hunts for a sync header, forwards payload words.
// Define WIDE_UART_DEFRAMER_CKSUM_EN to expect and check a trailing XOR checksum word.
module wide_uart_deframer #(
  parameter logic [15:0] SYNC    = 16'hA55A,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [39:0] m_axis_tuser,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] ok_count,
  output logic [15:0] err_count,
  output logic [15:0] drop_count
);

`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
  typedef enum logic [1:0] {StHunt, StPayload, StTrailer} state_e;
  logic [63:0] cksum_q, cksum_d;
`else
  typedef enum logic [0:0] {StHunt, StPayload} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [39:0] tag_q, tag_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] ok_q, err_q, drop_q;
  logic        drop_inc;
  logic [7:0]  hdr_len;
  logic        hdr_legal;

  assign hdr_len   = s_axis_tdata[47:40];
  assign hdr_legal = (s_axis_tdata[63:48] == SYNC) && (hdr_len != 8'd0) &&
                     (32'(hdr_len) <= MAX_LEN);

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tuser = tag_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;
  assign ok_count     = ok_q;
  assign err_count    = err_q;
  assign drop_count   = drop_q;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    tag_d         = tag_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    drop_inc      = 1'b0;
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
    cksum_d       = cksum_q;
`endif
    unique case (state_q)
      StHunt: begin
        if (s_axis_tvalid) begin
          if (hdr_legal) begin
            tag_d       = s_axis_tdata[39:0];
            remaining_d = hdr_len;
            state_d     = StPayload;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
            cksum_d     = s_axis_tdata;
`endif
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      StPayload: begin
        // Zero-latency pass-through: downstream ready is the bridge's ready.
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = (remaining_q == 8'd1);
        if (s_axis_tvalid && m_axis_tready) begin
          remaining_d = remaining_q - 8'd1;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
          cksum_d = cksum_q ^ s_axis_tdata;
          if (remaining_q == 8'd1) state_d = StTrailer;
`else
          if (remaining_q == 8'd1) begin
            state_d      = StHunt;
            frame_done_d = 1'b1;
          end
`endif
        end
      end
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
      StTrailer: begin
        if (s_axis_tvalid) begin
          frame_done_d = 1'b1;
          frame_err_d  = (s_axis_tdata != cksum_q);
          state_d      = StHunt;
        end
      end
`endif
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StHunt;
      remaining_q  <= 8'd0;
      tag_q        <= 40'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ok_q         <= 16'd0;
      err_q        <= 16'd0;
      drop_q       <= 16'd0;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
      cksum_q      <= 64'd0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      tag_q        <= tag_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
      // Counters saturate at all-ones.
      if (frame_done_d && !frame_err_d && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      if (frame_done_d && frame_err_d && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_wide_uart_deframer.sv
// Self-checking bench for wide_uart_deframer: directed frames plus random streams
// checked against a word-list frame parser model.
module tb_wide_uart_deframer;

  localparam int unsigned MaxLen = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [39:0] m_axis_tuser;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] ok_count;
  logic [15:0] err_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  wide_uart_deframer #(
    .SYNC    (16'hA55A),
    .MAX_LEN (MaxLen)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .ok_count      (ok_count),
    .err_count     (err_count),
    .drop_count    (drop_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [39:0] user;
  } beat_t;

  logic [63:0] in_q[$];
  beat_t       exp_out[$];
  int          done_idx[$];
  logic        exp_err[$];
  int          total = 0;
  int          bad = 0;
  int          m_ok = 0;
  int          m_err = 0;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // Parses the queued input words into expected beats, completions and counter totals.
  task automatic build_model();
    int          i;
    int          len;
    logic [63:0] w;
    logic [63:0] x;
    logic [63:0] p;
    beat_t       b;
    exp_out.delete();
    done_idx.delete();
    exp_err.delete();
    i = 0;
    while (i < in_q.size()) begin
      w   = in_q[i];
      len = int'(w[47:40]);
      i++;
      if (w[63:48] == 16'hA55A && len >= 1 && len <= int'(MaxLen)) begin
        x = w;
        for (int k = 0; k < len; k++) begin
          p      = in_q[i + k];
          b.data = p;
          b.last = (k == len - 1);
          b.user = w[39:0];
          exp_out.push_back(b);
          x = x ^ p;
        end
        i += len;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
        done_idx.push_back(i);
        exp_err.push_back(in_q[i] != x);
        if (in_q[i] != x) m_err = sat(m_err);
        else m_ok = sat(m_ok);
        i++;
`else
        done_idx.push_back(i - 1);
        exp_err.push_back(1'b0);
        m_ok = sat(m_ok);
`endif
      end else begin
        m_drop = sat(m_drop);
      end
    end
  endtask

  task automatic push_frame(input logic [39:0] tag, input int len, input bit corrupt);
    logic [63:0] x;
    logic [63:0] p;
    x = {16'hA55A, 8'(len), tag};
    in_q.push_back(x);
    for (int k = 0; k < len; k++) begin
      // Some payload words look like headers; they must still be forwarded as data.
      p = ($urandom_range(0, 3) == 0) ? {16'hA55A, 8'd1, 40'(k)} : {$urandom, $urandom};
      in_q.push_back(p);
      x = x ^ p;
    end
    if (corrupt) x = ~x;
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
    in_q.push_back(x);
`endif
  endtask

  task automatic push_junk();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0: if (w[63:48] == 16'hA55A) w[63:48] = 16'h1234;
      1: w[63:40] = {16'hA55A, 8'd0};
      default: w[63:40] = {16'hA55A, 8'(MaxLen + 1)};
    endcase
    in_q.push_back(w);
  endtask

  // mode 0: always valid/ready; 1: random valid/ready; 2: downstream stalls for 5 cycles.
  task automatic run_stream(input int mode);
    int    idx;
    int    cyc;
    bit    pend;
    bit    exp_fd;
    bit    sv;
    bit    mr;
    beat_t b;
    build_model();
    idx  = 0;
    cyc  = 0;
    pend = 1'b0;
    while ((idx < in_q.size() || pend) && cyc < 20000) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       begin sv = 1'b1; mr = 1'b1; end
        1:       begin sv = ($urandom_range(0, 3) != 0); mr = ($urandom_range(0, 3) != 0); end
        default: begin sv = 1'b1; mr = !(cyc >= 4 && cyc < 9); end
      endcase
      s_axis_tvalid = (idx < in_q.size()) && sv;
      s_axis_tdata  = (idx < in_q.size()) ? in_q[idx] : {$urandom, $urandom};
      m_axis_tready = mr;
      @(negedge clk);
      exp_fd = pend;
      pend   = 1'b0;
      chk("frame_done", 64'(frame_done), 64'(exp_fd));
      if (exp_fd) chk("frame_err", 64'(frame_err), 64'(exp_err.pop_front()));
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_expected", 64'(exp_out.size() > 0), 64'd1);
        if (exp_out.size() > 0) begin
          b = exp_out.pop_front();
          chk("m_tdata", m_axis_tdata, b.data);
          chk("m_tlast", 64'(m_axis_tlast), 64'(b.last));
          chk("m_tuser", 64'(m_axis_tuser), 64'(b.user));
        end
      end
      if (m_axis_tvalid) chk("s_ready_follows_m", 64'(s_axis_tready), 64'(m_axis_tready));
      if (s_axis_tvalid && s_axis_tready) begin
        if (done_idx.size() > 0 && done_idx[0] == idx) begin
          pend = 1'b1;
          void'(done_idx.pop_front());
        end
        idx++;
      end
      cyc++;
    end
    chk("stream_consumed", 64'(idx), 64'(in_q.size()));
    chk("beats_left", 64'(exp_out.size()), 64'd0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_frame_done", 64'(frame_done), 64'd0);
    end
    chk("ok_count", 64'(ok_count), 64'(m_ok));
    chk("err_count", 64'(err_count), 64'(m_err));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    in_q.delete();
  endtask

  task automatic check_reset_state();
    chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_ok_count", 64'(ok_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
  endtask

  initial begin
    logic [63:0] part[3];
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 64'd0;
    m_axis_tready = 1'b1;
    #12;
    check_reset_state();
    @(negedge clk);
    rst = 1'b1;

    // Documented example frames.
`ifdef WIDE_UART_DEFRAMER_CKSUM_EN
    in_q = '{64'hA55A030000000001, 64'd1, 64'd2, 64'd3, 64'hA55A030000000001,
             64'hA55A030000000001, 64'd1, 64'd2, 64'd3, 64'h0};
    run_stream(0);
    chk("example_ok", 64'(ok_count), 64'd1);
    chk("example_err", 64'(err_count), 64'd1);
`else
    in_q = '{64'hA55A020000000007, 64'd5, 64'd6};
    run_stream(0);
    chk("example_ok", 64'(ok_count), 64'd1);
    chk("example_err", 64'(err_count), 64'd0);
`endif

    // Junk and LEN=0 header are dropped, then a LEN=1 frame.
    in_q = '{64'h1234, 64'hA55A000000000000};
    push_frame(40'h12_3456_789A, 1, 1'b0);
    run_stream(0);
    chk("drop_two", 64'(drop_count), 64'd2);

    // Downstream stall in mid-payload.
    push_frame(40'h00_0000_0042, 6, 1'b0);
    run_stream(2);

    // Length boundary: MAX_LEN+1 is dropped, MAX_LEN is accepted.
    in_q.push_back({16'hA55A, 8'(MaxLen + 1), 40'h55});
    push_frame(40'hAB_CDEF_0123, int'(MaxLen), 1'b0);
    run_stream(1);

    // Reset after header and two of three payload words.
    part = '{64'hA55A03000000BEEF, 64'h11, 64'h22};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = part[k];
      m_axis_tready = 1'b1;
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    chk("mid_frame_tuser", 64'(m_axis_tuser), 64'h000000BEEF);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    chk("rst_held_frame_done", 64'(frame_done), 64'd0);
    rst    = 1'b1;
    m_ok   = 0;
    m_err  = 0;
    m_drop = 0;
    push_frame(40'h00_0000_0077, 3, 1'b0);
    run_stream(0);

    // Random mix of junk, good and corrupted frames.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) push_junk();
      else push_frame({$urandom, 8'($urandom)}, $urandom_range(1, 8), $urandom_range(0, 3) == 0);
    end
    run_stream(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_uart_deframer.md
# wide_uart_deframer

Receive-side frame parser sitting directly downstream of the 64-bit UART bridge's `m_axis` output. It hunts for a sync header in the stream of reassembled 64-bit words and forwards the payload words with `tlast` and a per-frame tag. With the checksum option compiled in, it also checks a trailing XOR checksum word. Per-frame status pulses and saturating statistics counters feed the host status registers.

## Interface
Parameters:
- `SYNC`, 16'hA55A: required value of header bits [63:48].
- `MAX_LEN`, 255: largest legal payload length in words (1..255).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  64  word from the UART bridge.
- `s_axis_tvalid`  in  1  input word valid.
- `s_axis_tready`  out  1  input word accepted when high with `tvalid`.
- `m_axis_tdata`  out  64  payload word.
- `m_axis_tvalid`  out  1  payload valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  final payload word of the frame.
- `m_axis_tuser`  out  40  frame tag (header bits [39:0]), held constant for the whole frame.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `frame_err`  out  1  valid only with `frame_done`; 1 means checksum mismatch.
- `ok_count`  out  16  frames completed without error; saturating.
- `err_count`  out  16  frames completed with error; saturating.
- `drop_count`  out  16  words discarded while hunting; saturating.

## Operation
- Header word format:
  - [63:48] sync
  - [47:40] LEN, the payload word count
  - [39:0] tag
- States: HUNT, PAYLOAD, TRAILER.
- **HUNT**
  - `s_axis_tready`=1 and `m_axis_tvalid`=0.
  - On an accepted word, the header is legal when [63:48]==SYNC and 1≤LEN≤MAX_LEN.
  - Legal header: latch tag and LEN into the remaining-word counter, set cksum=word, go to PAYLOAD.
  - Any other word: discard it and increment `drop_count`.
- **PAYLOAD** (combinational pass-through)
  - `m_axis_tdata`=`s_axis_tdata`, `m_axis_tvalid`=`s_axis_tvalid`, `s_axis_tready`=`m_axis_tready`.
  - `m_axis_tlast`=1 when remaining==1.
  - On each handshake: cksum ^= word, remaining -= 1.
  - On the last word: go to TRAILER, or HUNT when checksum is disabled.
- **TRAILER**
  - `s_axis_tready`=1 and `m_axis_tvalid`=0.
  - On an accepted word: `frame_err` = (word != cksum), pulse `frame_done`, go to HUNT.
- Counters:
  - `ok_count` or `err_count` increments on the same edge that raises `frame_done`.
  - All counters stick at 16'hFFFF.
- No payload length or tag check beyond the header rules. A word matching SYNC seen inside PAYLOAD is treated as payload.

## Timing
- Reset values:
  - state=HUNT; cksum, remaining and tag=0.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0.
  - `frame_done`=0, `frame_err`=0, all counters=0.
  - `s_axis_tready`=1, since HUNT asserts it.
- Payload latency is zero cycles (pass-through). Header and trailer words take one input handshake each and are never forwarded.
- `frame_done` and `frame_err` are registered: asserted in the cycle after the trailer handshake (or after the last payload handshake when checksum is disabled), high for exactly one cycle.
- A back-to-back header may be accepted in the cycle in which `frame_done` is high.
- Downstream stall in PAYLOAD back-pressures the bridge. State and counters hold.
- Reset asserted mid-frame abandons the frame: no `frame_done`, all state and counters return to reset values immediately (asynchronous).
- LEN=1: the first payload word carries `tlast`.

## Configuration
- `WIDE_UART_DEFRAMER_CKSUM_EN` defined:
  - a trailer word follows every payload, and TRAILER exists;
  - `frame_err` reflects the XOR comparison.
- Not defined:
  - no trailer word, and TRAILER and the cksum register are removed;
  - `frame_done` pulses after the last payload handshake with `frame_err`=0;
  - `err_count` stays 0.

## Test plan
- Checksum on. Stream 64'hA55A030000000001, then 1, 2, 3, then trailer 64'hA55A030000000001.
  - Expected: 1, 2, 3 forwarded with `tlast` on 3 and `tuser`=40'h0000000001.
  - One-cycle `frame_done` with `frame_err`=0; `ok_count`=1.
- Same frame with trailer 64'h0.
  - Expected: `frame_done` with `frame_err`=1; `err_count`=1; payload still forwarded.
- Words 64'h1234, 64'hA55A000000000000 (LEN=0), then a valid LEN=1 frame.
  - Expected: `drop_count`=2, then the single word is forwarded with `tlast`.
- `m_axis_tready` low for 5 cycles in mid-payload.
  - Expected: `s_axis_tready`=0 throughout; no data lost or duplicated; order preserved.
- Reset pulled low after 2 of 3 payload words.
  - Expected: no `frame_done`; counters=0; the next valid frame is parsed normally.
- Checksum off. 64'hA55A020000000007, then 5, 6.
  - Expected: `tlast` on 6; `frame_done` in the next cycle with `frame_err`=0; `ok_count`=1.
